ups_ca4l_regs: RTL and testbench

//  AXI4-Lite responder (slave) for the PS-side ca4l master port: the PL end of the ca4l bus.

---
 rtl/ups_ca4l_regs_if.sv | 35 +++
 rtl/ups_ca4l_regs.sv | 182 ++++++++++++++++++
 tb/tb_ups_ca4l_regs.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ups_ca4l_regs_if.sv
// ca4l AXI4-Lite bus between the PS master port and the PL register block.
// The master drives addresses, data and ready for responses; the slave drives the rest.
interface ups_ca4l_regs_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ups_ca4l_regs.sv
// AXI4-Lite register responder on the PL end of ca4l: ID, live status and NREGS-2 control regs.
// Optional UPS_CA4L_WSTRB_EN enables per-byte write strobes; otherwise writes update the full word.
module ups_ca4l_regs #(
  parameter int unsigned NREGS     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5550_5301,
  parameter logic [31:0] RST_VALUE = 32'h0000_0000
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  ups_ca4l_regs_if.slave       ca4l,
  input  logic [31:0]          status_i,
  output logic [NREGS*32-1:0]  regs_o,
  output logic [NREGS-1:0]     wr_stb_o
);
  localparam int unsigned IDXW = $clog2(NREGS);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic rdy_q;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:2] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q [2:NREGS-1];
  logic [NREGS-1:0][31:0] img;
  logic [IDXW-1:0] w_idx, r_idx;
  logic w_hit, w_ro, r_hit, commit, wr_en;
  logic [31:0] wr_word;
  logic unused_bits;

  assign unused_bits = ^{ca4l.awprot, ca4l.arprot, ca4l.awaddr[1:0], ca4l.araddr[1:0]};

  always_comb begin
    img[0] = ID_VALUE;
    img[1] = status_i;
    for (int unsigned k = 2; k < NREGS; k++) img[k] = ctrl_q[k];
  end
  assign regs_o = img;

  assign w_idx = awaddr_q[IDXW+1:2];
  assign w_hit = (awaddr_q[31:IDXW+2] == BASE_ADDR[31:IDXW+2]);
  assign w_ro  = (w_idx < IDXW'(2));
  assign r_idx = ca4l.araddr[IDXW+1:2];
  assign r_hit = (ca4l.araddr[31:IDXW+2] == BASE_ADDR[31:IDXW+2]);

`ifdef UPS_CA4L_WSTRB_EN
  always_comb begin
    wr_word = img[w_idx];
    for (int unsigned b = 0; b < 4; b++)
      if (wstrb_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_q;
  assign wr_word      = wdata_q;
`endif

  assign wr_en    = commit && w_hit && !w_ro;
  assign wr_stb_o = wr_en ? (NREGS'(1) << w_idx) : '0;

  assign ca4l.awready = rdy_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign ca4l.wready  = rdy_q && (w_state_q == W_IDLE) && !w_held_q;
  assign ca4l.bvalid  = bvalid_q;
  assign ca4l.bresp   = bresp_q;
  assign ca4l.arready = rdy_q && (r_state_q == R_IDLE);
  assign ca4l.rvalid  = rvalid_q;
  assign ca4l.rresp   = rresp_q;
  assign ca4l.rdata   = rdata_q;

  // AW and W latch independently; the commit happens once both holds are set.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (ca4l.awvalid && ca4l.awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = ca4l.awaddr[31:2];
        end
        if (ca4l.wvalid && ca4l.wready) begin
          w_held_d = 1'b1;
          wdata_d  = ca4l.wdata;
          wstrb_d  = ca4l.wstrb;
        end
        if (aw_held_q && w_held_q) begin
          commit    = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = !w_hit ? 2'b11 : (w_ro ? 2'b10 : 2'b00);
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (ca4l.bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ca4l.arvalid && ca4l.arready) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_hit ? img[r_idx] : '0;
          rresp_d   = r_hit ? 2'b00 : 2'b11;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (ca4l.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      rdy_q     <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 2; k < NREGS; k++) ctrl_q[k] <= RST_VALUE;
    end else begin
      for (int unsigned k = 2; k < NREGS; k++)
        if (wr_en && (w_idx == IDXW'(k))) ctrl_q[k] <= wr_word;
    end
  end
endmodule

// File: tb/tb_ups_ca4l_regs.sv
// Scoreboard bench for ups_ca4l_regs (NREGS=8); build with or without UPS_CA4L_WSTRB_EN.
module tb_ups_ca4l_regs;
  localparam logic [31:0] BASE = 32'h43C0_0000;
  localparam logic [31:0] ID   = 32'h5550_5301;
  localparam logic [31:0] RSTV = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic            fclk = 1'b0;
  logic            rst_n;
  logic [31:0]     status_i;
  logic [8*32-1:0] regs_o;
  logic [7:0]      wr_stb_o;

  ups_ca4l_regs_if bus ();

  ups_ca4l_regs #(
    .NREGS(8), .BASE_ADDR(BASE), .ID_VALUE(ID), .RST_VALUE(RSTV)
  ) dut (
    .fclk(fclk), .rst_n(rst_n), .ca4l(bus.slave),
    .status_i(status_i), .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  always #5 fclk = ~fclk;

  int tests = 0;
  int fails = 0;
  exp_t        rexp_q[$];
  logic [1:0]  wexp_q[$];
  logic [31:0] mdl [8];
  int          stb_cnt [8];
  int          stb_total = 0;

  always @(negedge fclk)
    for (int k = 0; k < 8; k++)
      if (wr_stb_o[k] === 1'b1) begin
        stb_cnt[k]++;
        stb_total++;
      end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
`ifndef UPS_CA4L_WSTRB_EN
    m = '1;
`endif
    return (old & ~m) | (nw & m);
  endfunction

  function automatic logic [8*32-1:0] model_image();
    logic [8*32-1:0] v;
    v[31:0]  = ID;
    v[63:32] = status_i;
    for (int k = 2; k < 8; k++) v[k*32 +: 32] = mdl[k];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    int t;
    bit aw_done, w_done, aw_fire, w_fire;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 20) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(negedge fclk); t++;
      if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_fire) begin bus.wvalid = 1'b0; w_done = 1; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    t = 0;
    while (bus.bvalid !== 1'b1 && t < 20) begin @(negedge fclk); t++; end
    ok = (bus.bvalid === 1'b1);
    resp = bus.bresp;
    if (bus.bready) @(negedge fclk);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int t;
    bus.araddr = addr; bus.arvalid = 1'b1; t = 0;
    while (bus.arready !== 1'b1 && t < 20) begin @(negedge fclk); t++; end
    @(negedge fclk);
    bus.arvalid = 1'b0;
    t = 0;
    while (bus.rvalid !== 1'b1 && t < 20) begin @(negedge fclk); t++; end
    ok = (bus.rvalid === 1'b1);
    data = bus.rdata; resp = bus.rresp;
    if (bus.rready) @(negedge fclk);
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arprot = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b1; status_i = 32'h0000_0000;
    for (int k = 0; k < 8; k++) mdl[k] = RSTV;
    repeat (3) @(negedge fclk);
    obs = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp,
           |bus.rdata, |wr_stb_o, 1'b0};
    tests++; if (obs !== 12'h0) begin fails++; $display("FAIL reset_outputs: got %h expected 000", obs); end
    tests++; if (regs_o !== model_image()) begin fails++; $display("FAIL reset_regs: got %h expected %h", regs_o, model_image()); end
    rst_n = 1'b1;
    obs = {9'b0, bus.awready, bus.wready, bus.arready};
    tests++; if (obs !== 12'h0) begin fails++; $display("FAIL ready_before_edge: got %h expected 000", obs); end
    @(negedge fclk);
    obs = {9'b0, bus.awready, bus.wready, bus.arready};
    tests++; if (obs !== 12'h7) begin fails++; $display("FAIL ready_after_edge: got %h expected 007", obs); end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; bit ok; int s0; exp_t e;
    s0 = stb_cnt[2];
    wexp_q.push_back(2'b00);
    axi_write(BASE + 32'h8, 32'h1234_5678, 4'hF, r, ok);
    mdl[2] = merge(mdl[2], 32'h1234_5678, 4'hF);
    tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL wr_bresp: got %b ok=%0d expected 00", r, ok); end
    tests++; if (stb_cnt[2] - s0 !== 1) begin fails++; $display("FAIL wr_stb2: got %0d pulses expected 1", stb_cnt[2] - s0); end
    rexp_q.push_back('{mdl[2], 2'b00});
    axi_read(BASE + 32'h8, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL rd_reg2: got %h/%b expected %h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_w_before_aw();
    int s0; logic [1:0] exp_r;
    s0 = stb_cnt[3];
    wexp_q.push_back(2'b00);
    bus.wdata = 32'hCAFE_0003; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge fclk); bus.wvalid = 1'b0;
    repeat (2) @(negedge fclk);
    tests++; if (bus.bvalid !== 1'b0) begin fails++; $display("FAIL w_only_bvalid: got %b expected 0", bus.bvalid); end
    bus.awaddr = BASE + 32'hC; bus.awvalid = 1'b1;
    @(negedge fclk); bus.awvalid = 1'b0;
    tests++; if ({bus.bvalid, wr_stb_o} !== 9'h008) begin fails++; $display("FAIL commit_cycle: got %h expected 008", {bus.bvalid, wr_stb_o}); end
    @(negedge fclk);
    exp_r = wexp_q.pop_front();
    tests++; if (bus.bvalid !== 1'b1 || bus.bresp !== exp_r) begin fails++; $display("FAIL w_first_bresp: got %b/%b expected 1/%b", bus.bvalid, bus.bresp, exp_r); end
    @(negedge fclk);
    mdl[3] = merge(mdl[3], 32'hCAFE_0003, 4'hF);
    tests++; if (stb_cnt[3] - s0 !== 1 || regs_o[3*32 +: 32] !== mdl[3]) begin fails++; $display("FAIL w_first_commit: got %0d/%h expected 1/%h", stb_cnt[3] - s0, regs_o[3*32 +: 32], mdl[3]); end
  endtask

  task automatic test_ro_regs();
    logic [31:0] d; logic [1:0] r; bit ok; int s0; exp_t e;
    rexp_q.push_back('{ID, 2'b00});
    axi_read(BASE, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL rd_id: got %h/%b expected %h/%b", d, r, e.data, e.resp); end
    status_i = 32'hA5A5_0001;
    rexp_q.push_back('{32'hA5A5_0001, 2'b00});
    axi_read(BASE + 32'h4, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL rd_status: got %h/%b expected %h/%b", d, r, e.data, e.resp); end
    s0 = stb_total;
    wexp_q.push_back(2'b10);
    axi_write(BASE, 32'hFFFF_FFFF, 4'hF, r, ok);
    tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL wr_id_bresp: got %b ok=%0d expected 10", r, ok); end
    tests++; if (stb_total !== s0 || regs_o !== model_image()) begin fails++; $display("FAIL wr_id_effect: strobes %0d regs %h", stb_total - s0, regs_o); end
  endtask

  task automatic test_decerr();
    logic [31:0] d; logic [1:0] r; bit ok; int s0; exp_t e;
    rexp_q.push_back('{32'h0, 2'b11});
    axi_read(BASE + 32'h100, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL rd_miss: got %h/%b expected %h/%b", d, r, e.data, e.resp); end
    s0 = stb_total;
    for (int i = 0; i < 2; i++) begin
      wexp_q.push_back(2'b11);
      axi_write(BASE + 32'h100 + 32'(i * 8), 32'hDEAD_BEEF, 4'hF, r, ok);
      tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL wr_miss_bresp%0d: got %b ok=%0d expected 11", i, r, ok); end
    end
    tests++; if (stb_total !== s0 || regs_o !== model_image()) begin fails++; $display("FAIL wr_miss_effect: strobes %0d regs %h expected %h", stb_total - s0, regs_o, model_image()); end
  endtask

  task automatic test_backpressure();
    bit stable; int t; exp_t e;
    bus.rready = 1'b0;
    rexp_q.push_back('{mdl[2], 2'b00});
    e = rexp_q.pop_front();
    bus.araddr = BASE + 32'h8; bus.arvalid = 1'b1;
    t = 0;
    while (bus.arready !== 1'b1 && t < 20) begin @(negedge fclk); t++; end
    @(negedge fclk);
    bus.araddr = BASE + 32'hC;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rvalid !== 1'b1 || bus.rdata !== e.data || bus.rresp !== e.resp || bus.arready !== 1'b0) stable = 0;
      @(negedge fclk);
    end
    bus.arvalid = 1'b0;
    tests++; if (!stable) begin fails++; $display("FAIL bp_hold: got %b/%h/%b expected 1/%h/%b", bus.rvalid, bus.rdata, bus.rresp, e.data, e.resp); end
    bus.rready = 1'b1;
    @(negedge fclk);
    tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL bp_release: got rvalid %b expected 0", bus.rvalid); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; bit ok; int s0; exp_t e;
    s0 = stb_cnt[2];
    wexp_q.push_back(2'b00);
    axi_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, r, ok);
    mdl[2] = merge(mdl[2], 32'hFFFF_FFFF, 4'hF);
    tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL strb_w1: got %b expected 00", r); end
    wexp_q.push_back(2'b00);
    axi_write(BASE + 32'h8, 32'h0000_0000, 4'b0010, r, ok);
    mdl[2] = merge(mdl[2], 32'h0000_0000, 4'b0010);
    tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL strb_w2: got %b expected 00", r); end
    rexp_q.push_back('{mdl[2], 2'b00});
    axi_read(BASE + 32'h8, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data) begin fails++; $display("FAIL strb_lane1: got %h expected %h", d, e.data); end
    wexp_q.push_back(2'b00);
    axi_write(BASE + 32'h8, 32'h1111_1111, 4'b0000, r, ok);
    mdl[2] = merge(mdl[2], 32'h1111_1111, 4'b0000);
    tests++; if (!ok || r !== wexp_q.pop_front() || regs_o[2*32 +: 32] !== mdl[2]) begin fails++; $display("FAIL strb_none: got %b/%h expected 00/%h", r, regs_o[2*32 +: 32], mdl[2]); end
    tests++; if (stb_cnt[2] - s0 !== 3) begin fails++; $display("FAIL strb_pulses: got %0d expected 3", stb_cnt[2] - s0); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] nv, d; logic [1:0] r; bit ok; exp_t e;
    nv = 32'h0BAD_F00D;
    rexp_q.push_back('{mdl[4], 2'b00});
    bus.awaddr = BASE + 32'h10; bus.wdata = nv; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge fclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    @(negedge fclk);
    bus.arvalid = 1'b0;
    e = rexp_q.pop_front();
    tests++; if ({bus.rvalid, bus.bvalid} !== 2'b11 || bus.rdata !== e.data) begin fails++; $display("FAIL same_cycle_old: got %b%b/%h expected 11/%h", bus.rvalid, bus.bvalid, bus.rdata, e.data); end
    @(negedge fclk);
    mdl[4] = merge(mdl[4], nv, 4'hF);
    rexp_q.push_back('{mdl[4], 2'b00});
    axi_read(BASE + 32'h10, d, r, ok);
    e = rexp_q.pop_front();
    tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL same_cycle_new: got %h/%b expected %h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, v; logic [1:0] r; bit ok; int idx; exp_t e;
    status_i = 32'h5A5A_C3C3;
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(7, 2);
      v = $urandom;
      wexp_q.push_back(2'b00);
      axi_write(BASE + 32'(idx * 4), v, 4'hF, r, ok);
      mdl[idx] = merge(mdl[idx], v, 4'hF);
      tests++; if (!ok || r !== wexp_q.pop_front()) begin fails++; $display("FAIL b2b_wr%0d: got %b expected 00", i, r); end
    end
    for (int k = 0; k < 8; k++) begin
      rexp_q.push_back('{(k == 0) ? ID : (k == 1) ? status_i : mdl[k], 2'b00});
      axi_read(BASE + 32'(k * 4) + 32'(k % 4), d, r, ok);
      e = rexp_q.pop_front();
      tests++; if (!ok || d !== e.data || r !== e.resp) begin fails++; $display("FAIL b2b_rd%0d: got %h/%b expected %h/%b", k, d, r, e.data, e.resp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    bus.rready = 1'b0; bus.bready = 1'b0;
    bus.araddr = BASE + 32'h8; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h14; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge fclk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge fclk);
    tests++; if ({bus.rvalid, bus.bvalid} !== 2'b11) begin fails++; $display("FAIL mid_pending: got %b%b expected 11", bus.rvalid, bus.bvalid); end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 2; k < 8; k++) mdl[k] = RSTV;
    obs = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, |bus.rdata};
    tests++; if (obs !== 10'h0 || wr_stb_o !== 8'h0) begin fails++; $display("FAIL mid_reset_out: got %h/%h expected 000/00", obs, wr_stb_o); end
    tests++; if (regs_o !== model_image()) begin fails++; $display("FAIL mid_reset_regs: got %h expected %h", regs_o, model_image()); end
    @(negedge fclk);
    rst_n = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge fclk);
    tests++; if ({bus.awready, bus.wready, bus.arready, bus.rvalid, bus.bvalid} !== 5'b11100) begin fails++; $display("FAIL mid_recover: got %b expected 11100", {bus.awready, bus.wready, bus.arready, bus.rvalid, bus.bvalid}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_ro_regs();
    test_decerr();
    test_backpressure();
    test_wstrb();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
